trap_sequencer: RTL and testbench

Sequences every entry into and return from the machine-mode trap handler for the core. Sits between the datapath/decoder and `csrUnit`:
- collects synchronous exception flags, the timer interrupt request (`csrUnit.mtime_exc_o`) and `mret`;
- prioritises them and drives `csrUnit`'s `jumpingToMtvec_i`, `excCause_i`, `trapInfo_i` and `pc_i` from registered values;
- redirects the fetch PC to `mtvec` or `mepc` while stalling the datapath.

---
 rtl/trap_sequencer_if.sv | 58 +++++
 rtl/trap_sequencer.sv | 170 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer_if
// Description : Bundle between the datapath/csrUnit side and the trap
//               sequencer: retire-stage flags in, trap strobes and fetch
//               redirect out.
// Revision    : 1.0 - initial release
// ============================================================================
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  // Retire-stage inputs
  logic            retire_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] nextPc_i;
  logic [XLEN-1:0] instr_i;
  logic [XLEN-1:0] badAddr_i;
  logic            instrMisaligned_i;
  logic            illegalInstr_i;
  logic            ebreak_i;
  logic            ecall_i;
  logic            storeMisaligned_i;
  logic            loadMisaligned_i;
  logic            mret_i;
  logic            mtimeIrq_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  // Sequencer outputs
  logic            jumpingToMtvec_o;
  logic [XLEN-1:0] excCause_o;
  logic [XLEN-1:0] trapInfo_o;
  logic [XLEN-1:0] trapPc_o;
  logic            pcOverride_o;
  logic [XLEN-1:0] pcOverrideValue_o;
  logic            stall_o;
  logic            mretRestore_o;

  // Core side: drives retire information, consumes trap control
  modport master (
    output retire_i, pc_i, nextPc_i, instr_i, badAddr_i,
           instrMisaligned_i, illegalInstr_i, ebreak_i, ecall_i,
           storeMisaligned_i, loadMisaligned_i, mret_i, mtimeIrq_i,
           mtvec_i, mepc_i,
    input  jumpingToMtvec_o, excCause_o, trapInfo_o, trapPc_o,
           pcOverride_o, pcOverrideValue_o, stall_o, mretRestore_o
  );

  // Sequencer side
  modport slave (
    input  retire_i, pc_i, nextPc_i, instr_i, badAddr_i,
           instrMisaligned_i, illegalInstr_i, ebreak_i, ecall_i,
           storeMisaligned_i, loadMisaligned_i, mret_i, mtimeIrq_i,
           mtvec_i, mepc_i,
    output jumpingToMtvec_o, excCause_o, trapInfo_o, trapPc_o,
           pcOverride_o, pcOverrideValue_o, stall_o, mretRestore_o
  );
endinterface
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Prioritises synchronous exceptions, the machine timer
//               interrupt and mret at instruction retire, then sequences
//               trap entry (ENTER -> REDIRECT) or trap return (MRET_RET)
//               while stalling the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer #(
  parameter int              XLEN        = 32,
  parameter bit              IRQ_EN      = 1'b1,
  parameter logic [XLEN-1:0] MTIME_CAUSE = 32'h8000_0007
) (
  input  wire logic       clk,
  input  wire logic       rst,
  trap_sequencer_if.slave bus
);

  localparam logic [1:0] c_RUN      = 2'd0;
  localparam logic [1:0] c_ENTER    = 2'd1;
  localparam logic [1:0] c_REDIRECT = 2'd2;
  localparam logic [1:0] c_MRET_RET = 2'd3;

  localparam logic [XLEN-1:0] c_CAUSE_IMISALIGN = XLEN'(0);
  localparam logic [XLEN-1:0] c_CAUSE_ILLEGAL   = XLEN'(2);
  localparam logic [XLEN-1:0] c_CAUSE_EBREAK    = XLEN'(3);
  localparam logic [XLEN-1:0] c_CAUSE_LMISALIGN = XLEN'(4);
  localparam logic [XLEN-1:0] c_CAUSE_SMISALIGN = XLEN'(6);
  localparam logic [XLEN-1:0] c_CAUSE_ECALL     = XLEN'(11);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_trap_pc;

  logic            w_sync_exc;
  logic            w_irq;
  logic            w_sample;
  logic            w_take_exc;
  logic            w_take_irq;
  logic            w_take_mret;
  logic [XLEN-1:0] w_exc_cause;
  logic [XLEN-1:0] w_exc_tval;

  logic            w_jump;
  logic            w_pc_override;
  logic [XLEN-1:0] w_pc_override_value;
  logic            w_stall;
  logic            w_mret_restore;

  // Events are only considered at an instruction boundary in RUN
  assign w_sample    = (r_state == c_RUN) && bus.retire_i;
  assign w_sync_exc  = bus.instrMisaligned_i | bus.illegalInstr_i | bus.ebreak_i |
                       bus.ecall_i | bus.storeMisaligned_i | bus.loadMisaligned_i;
  assign w_irq       = (IRQ_EN != 1'b0) && bus.mtimeIrq_i;
  assign w_take_exc  = w_sample && w_sync_exc;
  assign w_take_irq  = w_sample && !w_sync_exc && w_irq;
  assign w_take_mret = w_sample && !w_sync_exc && !w_irq && bus.mret_i;

  // Fixed-priority selection of the synchronous exception cause and tval
  always_comb begin
    w_exc_cause = '0;
    w_exc_tval  = '0;
    if (bus.instrMisaligned_i) begin
      w_exc_cause = c_CAUSE_IMISALIGN;
      w_exc_tval  = bus.badAddr_i;
    end else if (bus.illegalInstr_i) begin
      w_exc_cause = c_CAUSE_ILLEGAL;
      w_exc_tval  = bus.instr_i;
    end else if (bus.ebreak_i) begin
      w_exc_cause = c_CAUSE_EBREAK;
      w_exc_tval  = bus.pc_i;
    end else if (bus.ecall_i) begin
      w_exc_cause = c_CAUSE_ECALL;
    end else if (bus.storeMisaligned_i) begin
      w_exc_cause = c_CAUSE_SMISALIGN;
      w_exc_tval  = bus.badAddr_i;
    end else if (bus.loadMisaligned_i) begin
      w_exc_cause = c_CAUSE_LMISALIGN;
      w_exc_tval  = bus.badAddr_i;
    end
  end

  // Capture registers: loaded on trap acceptance, held otherwise.
  // An interrupt lets the instruction complete, so mepc is the next PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cause   <= '0;
      r_tval    <= '0;
      r_trap_pc <= '0;
    end else if (w_take_exc) begin
      r_cause   <= w_exc_cause;
      r_tval    <= w_exc_tval;
      r_trap_pc <= bus.pc_i;
    end else if (w_take_irq) begin
      r_cause   <= MTIME_CAUSE;
      r_tval    <= '0;
      r_trap_pc <= bus.nextPc_i;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_RUN: begin
        if (w_take_exc || w_take_irq) begin
          w_next_state = c_ENTER;
        end else if (w_take_mret) begin
          w_next_state = c_MRET_RET;
        end
      end
      c_ENTER:    w_next_state = c_REDIRECT;
      c_REDIRECT: w_next_state = c_RUN;
      c_MRET_RET: w_next_state = c_RUN;
      default:    w_next_state = c_RUN;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    w_jump              = 1'b0;
    w_pc_override       = 1'b0;
    w_pc_override_value = '0;
    w_stall             = 1'b0;
    w_mret_restore      = 1'b0;
    case (r_state)
      c_ENTER: begin
        w_jump  = 1'b1;
        w_stall = 1'b1;
      end
      c_REDIRECT: begin
        w_pc_override       = 1'b1;
        w_pc_override_value = bus.mtvec_i;
        w_stall             = 1'b1;
      end
      c_MRET_RET: begin
        w_pc_override       = 1'b1;
        w_pc_override_value = bus.mepc_i;
        w_mret_restore      = 1'b1;
        w_stall             = 1'b1;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  assign bus.jumpingToMtvec_o  = w_jump;
  assign bus.excCause_o        = r_cause;
  assign bus.trapInfo_o        = r_tval;
  assign bus.trapPc_o          = r_trap_pc;
  assign bus.pcOverride_o      = w_pc_override;
  assign bus.pcOverrideValue_o = w_pc_override_value;
  assign bus.stall_o           = w_stall;
  assign bus.mretRestore_o     = w_mret_restore;

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Scoreboard bench for trap_sequencer. Stimulus pushes the
//               hand-computed trap-entry / redirect events it expects; a
//               monitor pops and compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

  localparam int c_KIND_ENTER = 0;
  localparam int c_KIND_REDIR = 1;
  localparam int c_KIND_MRET  = 2;
  localparam logic [31:0] c_MTVEC = 32'h0000_0200;

  typedef struct {
    int          kind;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] pc;
    logic [31:0] target;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_cmp;
  int   n_err;
  int   cnt2;

  trap_sequencer_if #(.XLEN(32)) bif ();
  trap_sequencer_if #(.XLEN(32)) bif2 ();

  trap_sequencer #(.XLEN(32), .IRQ_EN(1'b1), .MTIME_CAUSE(32'h8000_0007)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  trap_sequencer #(.XLEN(32), .IRQ_EN(1'b0), .MTIME_CAUSE(32'h8000_0007)) u_dut_noirq (
    .clk (clk),
    .rst (rst),
    .bus (bif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic push_enter(input logic [31:0] cause, input logic [31:0] tval, input logic [31:0] pc);
    exp_t e;
    e.kind = c_KIND_ENTER; e.cause = cause; e.tval = tval; e.pc = pc; e.target = '0;
    q.push_back(e);
  endtask

  task automatic push_redir(input int kind, input logic [31:0] target);
    exp_t e;
    e.kind = kind; e.cause = '0; e.tval = '0; e.pc = '0; e.target = target;
    q.push_back(e);
  endtask

  // flags = {instrMisaligned, illegal, ebreak, ecall, storeMisaligned, loadMisaligned}
  task automatic set_flags(input logic [5:0] f, input logic m);
    bif.instrMisaligned_i = f[5];
    bif.illegalInstr_i    = f[4];
    bif.ebreak_i          = f[3];
    bif.ecall_i           = f[2];
    bif.storeMisaligned_i = f[1];
    bif.loadMisaligned_i  = f[0];
    bif.mret_i            = m;
  endtask

  // One retiring instruction, held for exactly one clock edge
  task automatic retire_one(input logic [5:0] f, input logic m, input logic [31:0] pc,
                            input logic [31:0] npc, input logic [31:0] instr,
                            input logic [31:0] bad);
    bif.retire_i  = 1'b1;
    bif.pc_i      = pc;
    bif.nextPc_i  = npc;
    bif.instr_i   = instr;
    bif.badAddr_i = bad;
    set_flags(f, m);
    @(posedge clk); #1;
    bif.retire_i = 1'b0;
    set_flags(6'b0, 1'b0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops one expected event for each trap entry or redirect
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("stall_moore", {31'b0, bif.stall_o}, {31'b0, bif.jumpingToMtvec_o | bif.pcOverride_o});
      if (!bif.pcOverride_o) chk("override_value_idle", bif.pcOverrideValue_o, 32'h0);
      if (bif.jumpingToMtvec_o || bif.pcOverride_o) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: jump=%0b override=%0b value=%08h, none expected",
                   bif.jumpingToMtvec_o, bif.pcOverride_o, bif.pcOverrideValue_o);
        end else begin
          e = q.pop_front();
          if (bif.jumpingToMtvec_o) begin
            chk("event_kind", 32'(c_KIND_ENTER), 32'(e.kind));
            chk("excCause", bif.excCause_o, e.cause);
            chk("trapInfo", bif.trapInfo_o, e.tval);
            chk("trapPc", bif.trapPc_o, e.pc);
          end else begin
            chk("event_kind", bif.mretRestore_o ? 32'(c_KIND_MRET) : 32'(c_KIND_REDIR), 32'(e.kind));
            chk("override_target", bif.pcOverrideValue_o, e.target);
          end
        end
      end
      if (bif2.jumpingToMtvec_o || bif2.stall_o) cnt2++;
    end
  end

  initial begin
    int stall_cnt;
    n_cmp = 0; n_err = 0; cnt2 = 0;
    rst = 1'b1;
    bif.retire_i = 1'b0; bif.pc_i = '0; bif.nextPc_i = '0; bif.instr_i = '0;
    bif.badAddr_i = '0; bif.mtimeIrq_i = 1'b0; bif.mtvec_i = c_MTVEC; bif.mepc_i = '0;
    set_flags(6'b0, 1'b0);
    bif2.retire_i = 1'b0; bif2.pc_i = '0; bif2.nextPc_i = '0; bif2.instr_i = '0;
    bif2.badAddr_i = '0; bif2.instrMisaligned_i = 1'b0; bif2.illegalInstr_i = 1'b0;
    bif2.ebreak_i = 1'b0; bif2.ecall_i = 1'b0; bif2.storeMisaligned_i = 1'b0;
    bif2.loadMisaligned_i = 1'b0; bif2.mret_i = 1'b0; bif2.mtimeIrq_i = 1'b0;
    bif2.mtvec_i = c_MTVEC; bif2.mepc_i = '0;

    // Reset state
    #12;
    chk("rst_jump", {31'b0, bif.jumpingToMtvec_o}, 32'h0);
    chk("rst_stall", {31'b0, bif.stall_o}, 32'h0);
    chk("rst_cause", bif.excCause_o, 32'h0);
    chk("rst_override", {31'b0, bif.pcOverride_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(2);

    // Illegal instruction, with stall length measured
    push_enter(32'd2, 32'hFFFF_FFFF, 32'h100);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b010000, 1'b0, 32'h100, 32'h104, 32'hFFFF_FFFF, 32'h0);
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bif.stall_o) stall_cnt++;
    end
    chk("stall_cycles", 32'(stall_cnt), 32'd2);
    @(posedge clk); #1;

    // load+ecall+irq -> ecall; then held irq taken at the very next boundary
    bif.mtimeIrq_i = 1'b1;
    push_enter(32'd11, 32'h0, 32'h300);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b000101, 1'b0, 32'h300, 32'h304, 32'h0000_0073, 32'h55);
    cycles(2);
    push_enter(32'h8000_0007, 32'h0, 32'h404);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b000000, 1'b0, 32'h400, 32'h404, 32'h0000_0013, 32'h0);
    bif.mtimeIrq_i = 1'b0;
    cycles(2);

    // All flags plus mret: instruction-misaligned wins
    push_enter(32'd0, 32'h0000_DEAD, 32'h500);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b111111, 1'b1, 32'h500, 32'h504, 32'h1234_5678, 32'h0000_DEAD);
    cycles(2);

    // ebreak: tval is the PC
    push_enter(32'd3, 32'h0000_0600, 32'h600);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b001000, 1'b0, 32'h600, 32'h604, 32'h0010_0073, 32'h0);
    cycles(2);

    // store beats load; then load alone
    push_enter(32'd6, 32'h0000_0077, 32'h700);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b000011, 1'b0, 32'h700, 32'h704, 32'h0, 32'h77);
    cycles(2);
    push_enter(32'd4, 32'h0000_0079, 32'h710);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b000001, 1'b0, 32'h710, 32'h714, 32'h0, 32'h79);
    cycles(2);

    // mret to mepc; returns to RUN after one stalled cycle
    bif.mepc_i = 32'h344;
    push_redir(c_KIND_MRET, 32'h344);
    retire_one(6'b000000, 1'b1, 32'h800, 32'h804, 32'h3020_0073, 32'h0);
    cycles(1);
    chk("mret_back_to_run_stall", {31'b0, bif.stall_o}, 32'h0);

    // mret with illegal set is an illegal-instruction trap
    push_enter(32'd2, 32'h3020_0073, 32'h810);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b010000, 1'b1, 32'h810, 32'h814, 32'h3020_0073, 32'h0);
    cycles(2);

    // Flags without retire are ignored
    bif.retire_i = 1'b0;
    set_flags(6'b111111, 1'b1);
    bif.mtimeIrq_i = 1'b1;
    cycles(5);
    set_flags(6'b0, 1'b0);
    bif.mtimeIrq_i = 1'b0;
    cycles(1);

    // Retiring events during ENTER/REDIRECT are dropped, not queued
    push_enter(32'd11, 32'h0, 32'h900);
    push_redir(c_KIND_REDIR, c_MTVEC);
    retire_one(6'b000100, 1'b0, 32'h900, 32'h904, 32'h73, 32'h0);
    bif.retire_i = 1'b1;
    set_flags(6'b111111, 1'b1);
    cycles(2);
    bif.retire_i = 1'b0;
    set_flags(6'b0, 1'b0);
    cycles(3);
    chk("dropped_events_no_stall", {31'b0, bif.stall_o}, 32'h0);

    // IRQ_EN=0 instance: a level timer interrupt never traps
    bif2.retire_i = 1'b1;
    bif2.mtimeIrq_i = 1'b1;
    cycles(100);
    bif2.retire_i = 1'b0;
    bif2.mtimeIrq_i = 1'b0;
    chk("noirq_trap_cycles", 32'(cnt2), 32'h0);

    // Asynchronous reset in the middle of REDIRECT
    push_enter(32'd2, 32'h0BAD_0BAD, 32'hA00);
    retire_one(6'b010000, 1'b0, 32'hA00, 32'hA04, 32'h0BAD_0BAD, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_override", {31'b0, bif.pcOverride_o}, 32'h0);
    chk("arst_override_value", bif.pcOverrideValue_o, 32'h0);
    chk("arst_stall", {31'b0, bif.stall_o}, 32'h0);
    chk("arst_cause", bif.excCause_o, 32'h0);
    chk("arst_tval", bif.trapInfo_o, 32'h0);
    chk("arst_trappc", bif.trapPc_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(3);
    chk("post_rst_stall", {31'b0, bif.stall_o}, 32'h0);
    chk("post_rst_cause", bif.excCause_o, 32'h0);

    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
